// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-order feature map, half-width line buffer.
// Optional feature macro: MAX_POOL_FRAME_LAST_EN adds out_last on the final window of each frame.
module max_pool_2x2 #(
    parameter int unsigned BITWIDTH   = 8,
    parameter int unsigned IMG_WIDTH  = 24,
    parameter int unsigned IMG_HEIGHT = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [BITWIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [BITWIDTH-1:0] out_data
`ifdef MAX_POOL_FRAME_LAST_EN
    ,
    output logic                       out_last
`endif
);

    localparam int unsigned LB_DEPTH = IMG_WIDTH / 2;
    localparam int unsigned COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned LB_W     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    if ((IMG_WIDTH == 0) || (IMG_WIDTH % 2 != 0)) begin : g_bad_width
        $error("max_pool_2x2: IMG_WIDTH must be even and non-zero");
    end
    if ((IMG_HEIGHT == 0) || (IMG_HEIGHT % 2 != 0)) begin : g_bad_height
        $error("max_pool_2x2: IMG_HEIGHT must be even and non-zero");
    end

    logic [COL_W-1:0]           col_q, col_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic signed [BITWIDTH-1:0] hold_q, hold_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [BITWIDTH-1:0] out_data_q, out_data_d;
    logic signed [BITWIDTH-1:0] linebuf_q [LB_DEPTH];

    logic                       in_fire_c;
    logic                       col_last_c;
    logic                       row_last_c;
    logic [LB_W-1:0]            lb_idx_c;
    logic signed [BITWIDTH-1:0] lb_rd_c;
    logic signed [BITWIDTH-1:0] h_max_c;
    logic signed [BITWIDTH-1:0] pool_c;
    logic                       lb_we_c;
    logic                       result_c;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Window datapath: horizontal pair max, then vertical max against the buffered upper pair.
    always_comb begin
        in_fire_c  = in_valid && in_ready;
        col_last_c = (col_q == COL_W'(IMG_WIDTH - 1));
        row_last_c = (row_q == ROW_W'(IMG_HEIGHT - 1));
        lb_idx_c   = LB_W'(col_q >> 1);
        lb_rd_c    = linebuf_q[lb_idx_c];
        h_max_c    = (hold_q > in_data) ? hold_q : in_data;
        pool_c     = (lb_rd_c > h_max_c) ? lb_rd_c : h_max_c;
        lb_we_c    = in_fire_c && col_q[0] && !row_q[0];
        result_c   = in_fire_c && col_q[0] && row_q[0];
    end

    // Position counters, hold register and output register next-state.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (in_fire_c) begin
            if (col_last_c) begin
                col_d = '0;
                row_d = row_last_c ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            if (!col_q[0]) begin
                hold_d = in_data;
            end
        end
        if (result_c) begin
            out_valid_d = 1'b1;
            out_data_d  = pool_c;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Line buffer holds upper-row pair maxima; contents need no reset.
    always_ff @(posedge clk) begin
        if (lb_we_c) begin
            linebuf_q[lb_idx_c] <= h_max_c;
        end
    end

`ifdef MAX_POOL_FRAME_LAST_EN
    logic out_last_q, out_last_d;

    always_comb begin
        out_last_d = out_last_q;
        if (result_c) begin
            out_last_d = row_last_c && col_last_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_last_q <= 1'b0;
        end else begin
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`endif

endmodule

// File: doc/max_pool_2x2.md
Name: max_pool_2x2

Overview:
- Streaming 2x2 / stride-2 max-pooling stage placed directly downstream of the ReLU activation.
- Consumes one signed activation per accepted beat in raster order: row-major, left to right, top to bottom.
- Emits one signed maximum per 2x2 window in raster order, feeding the next convolution layer.
- Uses a half-width line buffer so each input pixel is read exactly once.

Parameters:
- BITWIDTH, 8: width of signed activation data in and out.
- IMG_WIDTH, 24: input feature-map width in pixels. Must be even and >= 2.
- IMG_HEIGHT, 24: input feature-map height in pixels. Must be even and >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is presented this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  BITWIDTH  signed activation (ReLU output).
- out_valid  output  1  out_data holds a pooled result.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  BITWIDTH  signed pooled maximum.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, col=0, row=0, horizontal hold register=0, frame_last=0 (when enabled). Line buffer contents are don't-care.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). in_ready is 1 out of reset.
  - out_valid and out_data stay stable until accepted.
- Counters:
  - col runs 0..IMG_WIDTH-1 and advances on each input transfer.
  - At IMG_WIDTH-1, col wraps to 0 and row increments.
  - At the last pixel of row IMG_HEIGHT-1, row wraps to 0, starting the next frame with no gap.
- Even col: store in_data in the hold register.
- Odd col: h = signed max(hold, in_data). On a tie either operand is fine, since the values are identical.
  - Even row: write h into line buffer entry col>>1 (depth IMG_WIDTH/2).
  - Odd row: out_data <= signed max(linebuf[col>>1], h), out_valid <= 1 on the same edge.
- Latency: out_valid rises on the clock edge that accepts the bottom-right pixel of a window, i.e. the result is visible the cycle after that transfer.
- Output register update:
  - If an output transfer happens and no new result is produced on that edge, out_valid clears to 0.
  - If a new result is produced on the same edge as an output transfer, out_valid stays 1 and out_data takes the new value. Full throughput, no bubble.
- Comparisons are signed two's complement, so negative inputs are handled correctly even if the ReLU threshold is bypassed.
- No arithmetic growth: output width equals input width.
- Throughput: one input per cycle sustained. Output rate is 1/4 of the input rate, bursty on odd rows.
- Reset mid-frame: everything returns to reset values immediately. The next accepted pixel is treated as pixel (0,0) of a new frame. Any pending output is discarded.
- Elaboration: an odd or zero IMG_WIDTH/IMG_HEIGHT triggers a generate-time $error.

Optional Feature:
- Macro: MAX_POOL_FRAME_LAST_EN.
- When defined:
  - Adds output port out_last (1 bit, reset 0).
  - out_last is asserted alongside out_valid for the final pooled result of a frame (window at row IMG_HEIGHT-1, col IMG_WIDTH-1).
  - out_last is held with out_data until accepted.
  - out_last is cleared when a non-last result is loaded.
- When not defined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset and idle, IMG_WIDTH=4, IMG_HEIGHT=2: release rst_n with no input -> out_valid=0, out_data=0, in_ready=1.
- Single frame, IMG_WIDTH=4, IMG_HEIGHT=2, rows {1,5,2,3} and {4,0,7,6}, in_valid held high, out_ready=1 -> exactly two results, 5 then 7. Each out_valid appears one cycle after the pixel at col 1 and col 3 of row 1.
- Signed values: window {-3,-8,-1,-128} -> out_data=-1 (0xFF at BITWIDTH=8).
- Backpressure: out_ready=0 during the frame above -> first result 5 held. in_ready=0 while out_valid=1. The second window is not lost. Release out_ready -> 5 then 7 delivered in order.
- Back-to-back frames plus mid-frame reset: two frames streamed continuously -> 4 correct outputs. Then pulse rst_n low after 3 pixels of a third frame -> no output. The next frame pools from (0,0) correctly.
- With MAX_POOL_FRAME_LAST_EN defined, IMG_WIDTH=4, IMG_HEIGHT=4 -> 4 outputs, out_last=1 only on the 4th.
